// File: rtl/prio_encoder_q.sv
`default_nettype none
// ============================================================================
// Module      : prio_encoder_q
// Description : Registered N-input priority encoder with valid/ready output.
//               Request events (rising edges, or levels when EDGE=0) are
//               latched into a pending vector. The highest-priority pending
//               index is issued through a valid/ready output register, with
//               one grant per accepted transfer. The active-high gs/eo cascade
//               outputs allow several instances to be chained.
//               Optional macro PRIO_ENC_RR_EN: when defined, a round-robin
//               pointer sets the priority order. When undefined, bit N-1
//               always has the highest priority.
// Ports       : clk        - clock, rising edge
//               rst        - asynchronous reset, active-high
//               en         - enable; 0 blocks capture and new grants
//               req[N-1:0] - request lines
//               out_ready  - consumer accepts out_idx while out_valid=1
//               out_valid  - out_idx holds a grant
//               out_idx    - granted request index
//               gs         - group select: something pending or issued
//               eo         - enable out: en & ~gs
// Revision    : 1.0 - initial release
// ============================================================================
module prio_encoder_q #(
   parameter  int N     = 8,
   parameter  int EDGE  = 1,
   localparam int IDX_W = (N > 1) ? $clog2(N) : 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic [N-1:0]     req,
   input  logic             out_ready,
   output logic             out_valid,
   output logic [IDX_W-1:0] out_idx,
   output logic             gs,
   output logic             eo
);

   localparam logic [N-1:0] c_one = {{(N-1){1'b0}}, 1'b1};

   logic [N-1:0]     r_req_d;
   logic [N-1:0]     r_pending;
   logic             r_out_valid;
   logic [IDX_W-1:0] r_out_idx;

   logic [N-1:0]     w_new_raw;
   logic [N-1:0]     w_new;
   logic [N-1:0]     w_clr;
   logic             w_load;
   logic [IDX_W-1:0] w_sel;

   // Edge mode captures only 0->1 transitions. Events that arrive while en=0
   // are discarded rather than deferred.
   assign w_new_raw = (EDGE != 0) ? (req & ~r_req_d) : req;
   assign w_new     = en ? w_new_raw : '0;

   assign w_load = en & (|r_pending) & (~r_out_valid | out_ready);
   assign w_clr  = w_load ? (c_one << w_sel) : '0;

`ifdef PRIO_ENC_RR_EN
   logic [IDX_W-1:0] r_ptr;

   // The search order is ptr, ptr-1, ..., 0, N-1, ..., ptr+1. Every index at
   // or below ptr beats every index above it. Within each group, the higher
   // index wins. Two ascending last-wins passes build this order: the
   // low-priority group first, then the group at or below ptr.
   always_comb begin
      logic [IDX_W-1:0] w_i;
      w_sel = '0;
      for (int i = 0; i < N; i++) begin
         w_i = IDX_W'(i);
         if (r_pending[w_i] && (w_i > r_ptr)) w_sel = w_i;
      end
      for (int i = 0; i < N; i++) begin
         w_i = IDX_W'(i);
         if (r_pending[w_i] && (w_i <= r_ptr)) w_sel = w_i;
      end
   end

   // After a grant, the index just below it takes the top priority. This
   // makes the granted index the lowest priority for the next search.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_ptr <= IDX_W'(N - 1);
      end else if (w_load) begin
         r_ptr <= (w_sel == '0) ? IDX_W'(N - 1) : (w_sel - IDX_W'(1));
      end
   end
`else
   // Fixed priority: an ascending scan where the last hit wins gives the
   // highest set bit.
   always_comb begin
      logic [IDX_W-1:0] w_i;
      w_sel = '0;
      for (int i = 0; i < N; i++) begin
         w_i = IDX_W'(i);
         if (r_pending[w_i]) w_sel = w_i;
      end
   end
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_req_d     <= '0;
         r_pending   <= '0;
         r_out_valid <= 1'b0;
         r_out_idx   <= '0;
      end else begin
         r_req_d <= req;
         // The grant clears its bit before new events are ORed in. An event on
         // the bit being granted therefore re-pends it and is not lost.
         r_pending <= (r_pending & ~w_clr) | w_new;
         if (w_load) begin
            r_out_valid <= 1'b1;
            r_out_idx   <= w_sel;
         end else if (r_out_valid && out_ready) begin
            r_out_valid <= 1'b0;
         end
      end
   end

   assign out_valid = r_out_valid;
   assign out_idx   = r_out_idx;
   assign gs        = (|r_pending) | r_out_valid;
   assign eo        = en & ~gs;

endmodule
`default_nettype wire

// File: tb/tb_prio_encoder_q.sv
`default_nettype none
// ============================================================================
// Module      : tb_prio_encoder_q
// Description : Self-checking bench for prio_encoder_q with N=8. It drives one
//               edge-mode instance and one level-mode instance in parallel.
//               Both are compared every cycle against a behavioural model.
//               Directed scenarios come first, then randomized traffic.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_prio_encoder_q;
   localparam int N = 8;

   logic       clk = 1'b0;
   logic       rst;
   logic       en;
   logic [7:0] req;
   logic       out_ready;

   logic       v0, v1, gs0, gs1, eo0, eo1;
   logic [2:0] i0, i1;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   prio_encoder_q #(.N(N), .EDGE(1)) dut_edge (
      .clk(clk), .rst(rst), .en(en), .req(req), .out_ready(out_ready),
      .out_valid(v0), .out_idx(i0), .gs(gs0), .eo(eo0)
   );

   prio_encoder_q #(.N(N), .EDGE(0)) dut_lvl (
      .clk(clk), .rst(rst), .en(en), .req(req), .out_ready(out_ready),
      .out_valid(v1), .out_idx(i1), .gs(gs1), .eo(eo1)
   );

   // Behavioural model. Index 0 follows the edge instance, index 1 the level instance.
   bit m_pend [2][N];
   bit m_reqd [2][N];
   bit m_valid[2];
   int m_idx  [2];
   int m_ptr  [2];

   task automatic m_reset();
      for (int u = 0; u < 2; u++) begin
         for (int b = 0; b < N; b++) begin
            m_pend[u][b] = 0;
            m_reqd[u][b] = 0;
         end
         m_valid[u] = 0;
         m_idx[u]   = 0;
         m_ptr[u]   = N - 1;
      end
   endtask

   function automatic bit any_pend(int u);
      for (int b = 0; b < N; b++) if (m_pend[u][b]) return 1;
      return 0;
   endfunction

   // Walks the search order from the top and returns the first pending index.
   function automatic int pick(int u);
`ifdef PRIO_ENC_RR_EN
      for (int k = 0; k < N; k++) begin
         int c;
         c = (m_ptr[u] - k + N) % N;
         if (m_pend[u][c]) return c;
      end
`else
      for (int c = N - 1; c >= 0; c--) if (m_pend[u][c]) return c;
`endif
      return 0;
   endfunction

   // Advances the model by one clock, using the inputs that are driven now.
   task automatic m_step(int u);
      bit ev[N];
      bit load;
      int sel;
      for (int b = 0; b < N; b++) begin
         ev[b] = en && req[b] && ((u == 1) || !m_reqd[u][b]);
      end
      load = en && any_pend(u) && (!m_valid[u] || out_ready);
      sel  = pick(u);
      if (load) m_pend[u][sel] = 0;
      for (int b = 0; b < N; b++) begin
         if (ev[b]) m_pend[u][b] = 1;
         m_reqd[u][b] = req[b];
      end
      if (load) begin
         m_valid[u] = 1;
         m_idx[u]   = sel;
         m_ptr[u]   = (sel == 0) ? N - 1 : sel - 1;
      end else if (m_valid[u] && out_ready) begin
         m_valid[u] = 0;
      end
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic check_all();
      bit g;
      for (int u = 0; u < 2; u++) begin
         g = any_pend(u) || m_valid[u];
         check((u == 0) ? "edge_valid" : "lvl_valid", (u == 0) ? 32'(v0) : 32'(v1), 32'(m_valid[u]));
         check((u == 0) ? "edge_idx"   : "lvl_idx",   (u == 0) ? 32'(i0) : 32'(i1), 32'(m_idx[u]));
         check((u == 0) ? "edge_gs"    : "lvl_gs",    (u == 0) ? 32'(gs0) : 32'(gs1), 32'(g));
         check((u == 0) ? "edge_eo"    : "lvl_eo",    (u == 0) ? 32'(eo0) : 32'(eo1), 32'(en && !g));
      end
   endtask

   // Drives the inputs at the negative edge, lets one rising edge occur, then
   // compares both instances at the next negative edge.
   task automatic cyc(input logic [7:0] r, input logic e, input logic rd);
      req       = r;
      en        = e;
      out_ready = rd;
      m_step(0);
      m_step(1);
      @(negedge clk);
      check_all();
   endtask

   initial begin
      int q[$];
      int n5, n1;
      logic [7:0] r;

      rst = 1'b1; en = 1'b0; req = '0; out_ready = 1'b0;
      m_reset();
      @(negedge clk);
      check_all();
      check("rst_eo_en0", 32'(eo0), 32'd0);
      en = 1'b1;
      #1;
      check("rst_eo_en1", 32'(eo0), 32'd1);
      @(negedge clk);
      rst = 1'b0;

      // Scenario 1: request pattern 200 gives grants 7, 6, 3 back to back.
      cyc(8'd0, 1, 1);
      cyc(8'd200, 1, 1);
      check("s1_no_valid_yet", 32'(v0), 32'd0);
      cyc(8'd200, 1, 1);
      check("s1_idx7", {31'(i0), v0}, {31'd7, 1'b1});
      cyc(8'd200, 1, 1);
      check("s1_idx6", {31'(i0), v0}, {31'd6, 1'b1});
      cyc(8'd200, 1, 1);
      check("s1_idx3", {31'(i0), v0}, {31'd3, 1'b1});
      cyc(8'd200, 1, 1);
      check("s1_drained", {29'd0, v0, gs0, eo0}, 32'b001);

      // Scenario 2: edges that arrive while en=0 are lost.
      cyc(8'd0, 0, 1);
      for (int k = 0; k < 3; k++) cyc(8'd100, 0, 1);
      check("s2_no_capture", {29'd0, v0, gs0, eo0}, 32'b000);
      cyc(8'd100, 1, 1);
      cyc(8'd100, 1, 1);
      check("s2_edge_lost", {29'd0, v0, gs0, eo0}, 32'b001);

      // Scenario 3: with out_ready low, the grant is held stable.
      cyc(8'd0, 1, 1);
      cyc(8'd0, 1, 1);
      cyc(8'd0, 1, 0);
      cyc(8'd50, 1, 0);
      for (int k = 0; k < 6; k++) cyc(8'd50, 1, 0);
      check("s3_stall_gs_eo", {29'd0, v0, gs0, eo0}, 32'b110);
      for (int k = 0; k < 4; k++) cyc(8'd50, 1, 1);
      check("s3_drained", 32'(v0), 32'd0);

      // Scenario 4: an edge on req[5] at the edge that grants 5 re-pends it.
      cyc(8'h00, 1, 1);
      cyc(8'h00, 1, 1);
      cyc(8'h80, 1, 0);
      cyc(8'h20, 1, 0);
      cyc(8'h00, 1, 0);
      cyc(8'h22, 1, 1);
      check("s4_first5", {31'(i0), v0}, {31'd5, 1'b1});
      q.push_back(int'(i0));
      for (int k = 0; k < 3; k++) begin
         cyc(8'h00, 1, 1);
         if (v0) q.push_back(int'(i0));
      end
      n5 = 0; n1 = 0;
      foreach (q[j]) begin
         if (q[j] == 5) n5++;
         if (q[j] == 1) n1++;
      end
      check("s4_count5", 32'(n5), 32'd2);
      check("s4_count1", 32'(n1), 32'd1);
      check("s4_total", 32'(q.size()), 32'd3);

      // Scenario 5: asynchronous reset between clock edges.
      cyc(8'h00, 1, 1);
      cyc(8'h0E, 1, 0);
      cyc(8'h0E, 1, 0);
      check("s5_pre_valid", {29'd0, v0, gs0, 1'b0}, 32'b110);
      req = 8'h00;
      #2 rst = 1'b1;
      #1;
      check("s5_async_clear", {27'd0, v0, i0, gs0}, 32'd0);
      m_reset();
      @(negedge clk);
      check_all();
      rst = 1'b0;
      for (int k = 0; k < 3; k++) cyc(8'h00, 1, 1);
      check("s5_no_grant", {30'd0, v0, gs0}, 32'd0);

      // Scenario 6: all requests held high. The level instance keeps granting.
      for (int k = 0; k < 20; k++) cyc(8'hFF, 1, 1);
      check("s6_lvl_valid", 32'(v1), 32'd1);

      // Randomized traffic.
      for (int k = 0; k < 400; k++) begin
         r = 8'($urandom) & 8'($urandom);
         cyc(r, ($urandom_range(0, 9) != 0), ($urandom_range(0, 3) != 0));
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
`default_nettype wire
